// File: rtl/tx_sched_pkg.sv
// ---------------------------------------------------------------------------
// tx_sched_pkg
// Shared types and default sizes for the USB transmit packet scheduler.
//   sched_state_t      : scheduler FSM states
//   LEN_W_DEF          : default width of the data-packet length field
//   MAX_ND_STREAK_DEF  : default cap on consecutive non-data grants while a
//                        data packet is waiting
// ---------------------------------------------------------------------------
package tx_sched_pkg;

   localparam int LEN_W_DEF         = 10;
   localparam int MAX_ND_STREAK_DEF = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ND_SEND = 2'd1,
      D_SEND  = 2'd2
   } sched_state_t;

endpackage

// File: rtl/tx_len_counter.sv
// ---------------------------------------------------------------------------
// tx_len_counter
// Tracks the bytes still to send of the current data packet.
//   clk, srst   : clock, synchronous active-high reset
//   load        : capture load_len as both remaining count and packet length
//   load_len    : packet length in bytes (PID included)
//   dec         : one byte of the packet was handed to the encoder
//   is_first    : next byte is the first of the packet (sop)
//   is_last     : next byte is the last of the packet (eop)
// ---------------------------------------------------------------------------
module tx_len_counter
   import tx_sched_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             load,
   input  logic [LEN_W-1:0] load_len,
   input  logic             dec,
   output logic             is_first,
   output logic             is_last
);

   logic [LEN_W-1:0] remaining_q, remaining_d;
   logic [LEN_W-1:0] len_q, len_d;

   always_comb begin
      remaining_d = remaining_q;
      len_d       = len_q;
      if (load) begin
         remaining_d = load_len;
         len_d       = load_len;
      end else if (dec && (remaining_q > LEN_W'(1))) begin
         // The eop transfer leaves the count at 1; the FSM exits on it.
         remaining_d = remaining_q - LEN_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         remaining_q <= '0;
         len_q       <= '0;
      end else begin
         remaining_q <= remaining_d;
         len_q       <= len_d;
      end
   end

   assign is_first = (remaining_q != '0) && (remaining_q == len_q);
   assign is_last  = (remaining_q == LEN_W'(1));

endmodule

// File: rtl/tx_pkt_scheduler.sv
// ---------------------------------------------------------------------------
// tx_pkt_scheduler
// Shares the USB transmitter byte stream between the non-data FIFO (1-byte
// handshake packets) and the data FIFO (multi-byte data packets). Arbitrates
// in IDLE at packet boundaries, pops the granted FIFO on each encoder
// handshake and frames bytes with sop/eop.
//   clk, n_rst                : clock, synchronous ACTIVE-HIGH reset
//   nd_empty/nd_r_data        : non-data FIFO status and show-ahead head byte
//   nd_r_enable               : non-data FIFO pop
//   d_empty/d_r_data          : data FIFO status and show-ahead head byte
//   d_r_enable                : data FIFO pop
//   d_pkt_req/d_pkt_len       : complete data packet waiting, and its length
//   d_pkt_ack                 : pulse, length accepted / packet granted
//   tx_data/tx_valid/tx_ready : byte stream to the encoder
//   tx_sop/tx_eop             : first / last byte of the packet
//   grant_nd                  : current packet comes from the non-data FIFO
//   busy                      : a packet is being sent
//   err_underrun              : sticky, data FIFO ran dry mid-packet
//   err_len                   : pulse, zero-length data packet dropped
// ---------------------------------------------------------------------------
module tx_pkt_scheduler
   import tx_sched_pkg::*;
#(
   parameter int LEN_W         = LEN_W_DEF,
   parameter int MAX_ND_STREAK = MAX_ND_STREAK_DEF
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             nd_empty,
   input  logic [7:0]       nd_r_data,
   output logic             nd_r_enable,
   input  logic             d_empty,
   input  logic [7:0]       d_r_data,
   output logic             d_r_enable,
   input  logic             d_pkt_req,
   input  logic [LEN_W-1:0] d_pkt_len,
   output logic             d_pkt_ack,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             tx_sop,
   output logic             tx_eop,
   output logic             grant_nd,
   output logic             busy,
   output logic             err_underrun,
   output logic             err_len
);

   localparam int STREAK_W = $clog2(MAX_ND_STREAK + 1);

   sched_state_t        state_q, state_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic                err_underrun_q, err_underrun_d;
   logic                cnt_load, cnt_dec;
   logic                is_first, is_last;
   logic                nd_ok, d_ok;

   tx_len_counter #(.LEN_W(LEN_W)) u_len_counter (
      .clk      (clk),
      .srst     (n_rst),
      .load     (cnt_load),
      .load_len (d_pkt_len),
      .dec      (cnt_dec),
      .is_first (is_first),
      .is_last  (is_last)
   );

   assign nd_ok = !nd_empty;
   assign d_ok  = d_pkt_req;

   // Outputs follow the FIFO heads combinationally so the pop lands in the
   // same cycle as the handshake. Everything is held at 0 while in reset so
   // no pop or ack can escape during the reset cycle.
   always_comb begin
      state_d        = state_q;
      streak_d       = streak_q;
      err_underrun_d = err_underrun_q;
      cnt_load       = 1'b0;
      cnt_dec        = 1'b0;
      nd_r_enable    = 1'b0;
      d_r_enable     = 1'b0;
      d_pkt_ack      = 1'b0;
      err_len        = 1'b0;
      tx_data        = 8'h00;
      tx_valid       = 1'b0;
      tx_sop         = 1'b0;
      tx_eop         = 1'b0;
      grant_nd       = 1'b0;
      busy           = 1'b0;
      if (!n_rst) begin
         case (state_q)
            IDLE: begin
               // Non-data wins unless it has starved a waiting data packet
               // for MAX_ND_STREAK grants in a row.
               if (nd_ok && (!d_ok || (streak_q < STREAK_W'(MAX_ND_STREAK)))) begin
                  state_d  = ND_SEND;
                  streak_d = d_ok ? streak_q + STREAK_W'(1) : '0;
               end else if (d_ok) begin
                  d_pkt_ack = 1'b1;
                  cnt_load  = 1'b1;
                  streak_d  = '0;
                  if (d_pkt_len == '0) begin
                     err_len = 1'b1;
                  end else begin
                     state_d = D_SEND;
                  end
               end else begin
                  streak_d = '0;
               end
            end
            ND_SEND: begin
               busy     = 1'b1;
               grant_nd = 1'b1;
               tx_data  = nd_r_data;
               tx_valid = nd_ok;
               tx_sop   = 1'b1;
               tx_eop   = 1'b1;
               if (nd_ok && tx_ready) begin
                  nd_r_enable = 1'b1;
                  state_d     = IDLE;
               end
            end
            D_SEND: begin
               busy     = 1'b1;
               tx_data  = d_r_data;
               tx_valid = !d_empty;
               tx_sop   = is_first;
               tx_eop   = is_last;
               if (d_empty) begin
                  // Packet was announced complete, so running dry here is
                  // an upstream fault; wait for the bytes and flag it.
                  err_underrun_d = 1'b1;
               end else if (tx_ready) begin
                  d_r_enable = 1'b1;
                  cnt_dec    = 1'b1;
                  if (is_last) begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (n_rst) begin
         state_q        <= IDLE;
         streak_q       <= '0;
         err_underrun_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         streak_q       <= streak_d;
         err_underrun_q <= err_underrun_d;
      end
   end

   assign err_underrun = err_underrun_q;

endmodule

// File: tb/tb_tx_pkt_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tx_pkt_scheduler
// Directed bench for tx_pkt_scheduler. The bench owns queue models of both
// FIFOs and the length descriptor stream, plus a queue of the byte transfers
// the encoder must see (built from packet-level arbitration rules). A compare
// process checks every handshake against that queue; directed checks pin
// cycle timing and flag behaviour with literal values.
// ---------------------------------------------------------------------------
module tb_tx_pkt_scheduler;

   localparam int LEN_W = 10;
   localparam int MAXS  = 4;

   typedef struct packed {
      logic [7:0] data;
      logic       sop;
      logic       eop;
      logic       nd;
   } xfer_t;

   logic             clk = 1'b0;
   logic             n_rst;
   logic             nd_empty;
   logic [7:0]       nd_r_data;
   logic             nd_r_enable;
   logic             d_empty;
   logic [7:0]       d_r_data;
   logic             d_r_enable;
   logic             d_pkt_req;
   logic [LEN_W-1:0] d_pkt_len;
   logic             d_pkt_ack;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic             tx_sop;
   logic             tx_eop;
   logic             grant_nd;
   logic             busy;
   logic             err_underrun;
   logic             err_len;

   always #5 clk = ~clk;

   tx_pkt_scheduler #(.LEN_W(LEN_W), .MAX_ND_STREAK(MAXS)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .nd_empty     (nd_empty),
      .nd_r_data    (nd_r_data),
      .nd_r_enable  (nd_r_enable),
      .d_empty      (d_empty),
      .d_r_data     (d_r_data),
      .d_r_enable   (d_r_enable),
      .d_pkt_req    (d_pkt_req),
      .d_pkt_len    (d_pkt_len),
      .d_pkt_ack    (d_pkt_ack),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .tx_sop       (tx_sop),
      .tx_eop       (tx_eop),
      .grant_nd     (grant_nd),
      .busy         (busy),
      .err_underrun (err_underrun),
      .err_len      (err_len)
   );

   logic [7:0] nd_fifo[$];
   logic [7:0] d_fifo[$];
   int         desc_q[$];
   xfer_t      exp_q[$];

   int total = 0;
   int bad   = 0;

   logic        pop_nd_s = 1'b0;
   logic        pop_d_s  = 1'b0;
   logic        ack_s    = 1'b0;
   logic        stalled_prev = 1'b0;
   logic [9:0]  held = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic drive();
      nd_empty  = (nd_fifo.size() == 0);
      nd_r_data = nd_empty ? 8'h00 : nd_fifo[0];
      d_empty   = (d_fifo.size() == 0);
      d_r_data  = d_empty ? 8'h00 : d_fifo[0];
      d_pkt_req = (desc_q.size() != 0);
      d_pkt_len = d_pkt_req ? LEN_W'(desc_q[0]) : '0;
   endtask

   // One clock: apply the pops/ack seen at the previous falling edge, then
   // present the new FIFO heads.
   task automatic cyc();
      @(posedge clk);
      #1;
      if (pop_nd_s && nd_fifo.size() > 0) void'(nd_fifo.pop_front());
      if (pop_d_s && d_fifo.size() > 0) void'(d_fifo.pop_front());
      if (ack_s && desc_q.size() > 0) void'(desc_q.pop_front());
      drive();
      #1;
   endtask

   function automatic logic [7:0] pkt_byte(input int i, input logic [7:0] pid, input logic [7:0] base);
      return (i == 0) ? pid : base + 8'(i - 1);
   endfunction

   task automatic exp_nd(input logic [7:0] b);
      exp_q.push_back(xfer_t'{b, 1'b1, 1'b1, 1'b1});
   endtask

   task automatic exp_dpkt(input int len, input logic [7:0] pid, input logic [7:0] base);
      for (int i = 0; i < len; i++)
         exp_q.push_back(xfer_t'{pkt_byte(i, pid, base), (i == 0), (i == len - 1), 1'b0});
   endtask

   // Loads the first 'fill' bytes of a data packet and announces its length.
   task automatic load_dpkt(input int len, input logic [7:0] pid, input logic [7:0] base, input int fill);
      for (int i = 0; i < fill; i++) d_fifo.push_back(pkt_byte(i, pid, base));
      desc_q.push_back(len);
   endtask

   task automatic drain(input string name, input int budget, output int n);
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < budget) begin
         cyc();
         n++;
      end
      chk({name, "_left"}, exp_q.size(), 0);
   endtask

   task automatic chk_all_zero(input string name);
      chk(name, {nd_r_enable, d_r_enable, d_pkt_ack, tx_valid, tx_sop, tx_eop,
                 grant_nd, busy, err_underrun, err_len, tx_data}, 0);
   endtask

   // Compare process: every handshake must match the next expected transfer,
   // pops only on handshakes, stalled bytes must stay put.
   always @(negedge clk) begin
      xfer_t e;
      pop_nd_s = nd_r_enable;
      pop_d_s  = d_r_enable;
      ack_s    = d_pkt_ack;
      if (n_rst === 1'b0) begin
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_xfer actual=%0h required=none", tx_data);
            end else begin
               e = exp_q.pop_front();
               chk("xfer", {tx_data, tx_sop, tx_eop, grant_nd}, e);
               chk("xfer_pops", {nd_r_enable, d_r_enable}, {e.nd, !e.nd});
            end
         end else begin
            chk("idle_pops", {nd_r_enable, d_r_enable}, 0);
         end
         if (stalled_prev && tx_valid)
            chk("stall_hold", {tx_data, tx_sop, tx_eop}, held);
         stalled_prev = tx_valid && !tx_ready;
         held         = {tx_data, tx_sop, tx_eop};
      end else begin
         stalled_prev = 1'b0;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, nd_left, d_left, streak, ndi;
      n_rst    = 1'b1;
      tx_ready = 1'b1;
      drive();
      cyc();
      cyc();
      chk_all_zero("reset_outputs");
      n_rst = 1'b0;
      cyc();

      // 1: single handshake byte, grant then send then idle
      nd_fifo.push_back(8'hD2);
      exp_nd(8'hD2);
      drive();
      #1;
      chk("t1_grant_busy", busy, 0);
      chk("t1_grant_valid", tx_valid, 0);
      cyc();
      chk("t1_byte", {tx_valid, tx_sop, tx_eop, grant_nd, tx_data}, {4'b1111, 8'hD2});
      chk("t1_pop", nd_r_enable, 1);
      cyc();
      chk("t1_idle", {busy, tx_valid}, 0);

      // 2: data packet C3 01 02
      load_dpkt(3, 8'hC3, 8'h01, 3);
      exp_dpkt(3, 8'hC3, 8'h01);
      drive();
      #1;
      chk("t2_ack", {d_pkt_ack, busy}, 2'b10);
      cyc();
      chk("t2_b0", {tx_valid, tx_sop, tx_eop, d_r_enable, tx_data}, {4'b1101, 8'hC3});
      chk("t2_ack_pulse", d_pkt_ack, 0);
      cyc();
      chk("t2_b1", {tx_valid, tx_sop, tx_eop, d_r_enable, tx_data}, {4'b1001, 8'h01});
      cyc();
      chk("t2_b2", {tx_valid, tx_sop, tx_eop, d_r_enable, tx_data}, {4'b1011, 8'h02});
      cyc();
      chk("t2_idle", busy, 0);
      chk("t2_fifo_drained", d_fifo.size(), 0);

      // 3: six handshake packets race one data packet; packet-level model
      for (int i = 0; i < 6; i++) nd_fifo.push_back(8'h10 + 8'(i));
      load_dpkt(2, 8'h4B, 8'h77, 2);
      nd_left = 6; d_left = 1; streak = 0; ndi = 0;
      while (nd_left > 0 || d_left > 0) begin
         if (nd_left > 0 && (d_left == 0 || streak < MAXS)) begin
            exp_nd(8'h10 + 8'(ndi));
            ndi++;
            nd_left--;
            streak = (d_left > 0) ? streak + 1 : 0;
         end else begin
            exp_dpkt(2, 8'h4B, 8'h77);
            d_left--;
            streak = 0;
         end
      end
      drive();
      drain("t3", 200, n);
      // six 2-cycle nd packets + one 3-cycle data packet, one grant cycle each
      chk("t3_cycles", n, 15);

      // 4: encoder stalls 3 cycles on the second byte
      load_dpkt(4, 8'h5A, 8'hA1, 4);
      exp_dpkt(4, 8'h5A, 8'hA1);
      drive();
      cyc();
      cyc();
      tx_ready = 1'b0;
      #1;
      chk("t4_stall0", {tx_valid, d_r_enable, tx_data}, {2'b10, 8'hA1});
      cyc();
      chk("t4_stall1", {tx_valid, d_r_enable, tx_data}, {2'b10, 8'hA1});
      cyc();
      chk("t4_stall2", {tx_valid, d_r_enable, tx_data}, {2'b10, 8'hA1});
      cyc();
      tx_ready = 1'b1;
      drain("t4", 50, n);

      // 5: data FIFO runs dry after the first byte of a 4-byte packet
      load_dpkt(4, 8'hB0, 8'hB1, 1);
      exp_dpkt(4, 8'hB0, 8'hB1);
      drive();
      cyc();
      cyc();
      chk("t5_dry", {tx_valid, busy, d_r_enable}, 3'b010);
      cyc();
      chk("t5_underrun", {err_underrun, tx_valid}, 2'b10);
      d_fifo.push_back(8'hB1);
      d_fifo.push_back(8'hB2);
      d_fifo.push_back(8'hB3);
      drive();
      drain("t5", 50, n);
      chk("t5_sticky", err_underrun, 1);

      // 6: reset while byte 2 of a 5-byte packet is on the bus
      load_dpkt(5, 8'hE0, 8'hE1, 5);
      exp_dpkt(5, 8'hE0, 8'hE1);
      drive();
      n = 0;
      while (!(tx_valid && tx_data == 8'hE1) && n < 20) begin
         cyc();
         n++;
      end
      chk("t6_at_byte2", {tx_valid, tx_data}, {1'b1, 8'hE1});
      n_rst = 1'b1;
      exp_q.delete();
      d_fifo.delete();
      desc_q.delete();
      drive();
      cyc();
      chk_all_zero("t6_reset_outputs");
      n_rst = 1'b0;
      cyc();
      chk("t6_idle", {busy, tx_valid, err_underrun}, 0);

      // zero-length data packet is dropped with an error pulse
      desc_q.push_back(0);
      drive();
      #1;
      chk("t6_len0", {err_len, d_pkt_ack, busy, d_r_enable}, 4'b1100);
      cyc();
      chk("t6_len0_after", {err_len, busy, d_pkt_req}, 0);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
